// File: rtl/text_screen_buffer_if.sv
// Byte-stream write port of the text screen buffer.
// Valid/ready handshake carrying one character or control code per transfer.
interface text_screen_buffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_screen_buffer.sv
// Character-cell text memory with cursor and control-code handling.
// Optional blinking cursor overlay: define TEXTBUF_CURSOR_EN.
module text_screen_buffer #(
   parameter int COLS         = 60,
   parameter int ROWS         = 17,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                       CLK_PIX,
   input  logic                       RST,
   text_screen_buffer_if.slave        wr,
   input  logic [6:0]                 rd_col,
   input  logic [4:0]                 rd_row,
   output logic [7:0]                 rd_char,
   output logic                       rd_cursor,
   input  logic                       frame_start,
   output logic [6:0]                 cursor_col,
   output logic [4:0]                 cursor_row,
   output logic                       busy
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   typedef enum logic [1:0] {CLEAR, IDLE, ROWCLR} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [CELLS];
   logic [AW-1:0] clr_addr, clr_end;
   logic [AW-1:0] cur_addr, row_base, rd_addr, waddr;
   logic [7:0]    wdata;
   logic          we;
   logic          idle, accept, row_adv, last_col, rd_in;
   logic          is_print, is_cr, is_lf, is_bs;
   logic [4:0]    row_nxt;

   assign idle        = (state == IDLE);
   assign wr.wr_ready = idle;
   assign busy        = ~idle;
   assign accept      = wr.wr_valid & idle;

   assign is_print = (wr.wr_data >= 8'h20) && (wr.wr_data <= 8'h7E);
   assign is_cr    = (wr.wr_data == 8'h0D);
   assign is_lf    = (wr.wr_data == 8'h0A);
   assign is_bs    = (wr.wr_data == 8'h08);

   assign last_col = (cursor_col == 7'(COLS - 1));
   assign row_nxt  = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
   assign row_adv  = accept & (is_lf | (is_print & last_col));
   assign cur_addr = AW'(cursor_row * COLS + cursor_col);
   assign row_base = AW'(row_nxt * COLS);

   assign rd_in   = ({1'b0, rd_col} < 8'(COLS)) && ({1'b0, rd_row} < 6'(ROWS));
   assign rd_addr = AW'(rd_row * COLS + rd_col);

   always_ff @(posedge CLK_PIX or posedge RST) begin
      if (RST) state <= CLEAR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         CLEAR, ROWCLR: if (clr_addr == clr_end) state_nxt = IDLE;
         IDLE:          if (row_adv) state_nxt = ROWCLR;
         default:       state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      we    = 1'b0;
      waddr = clr_addr;
      wdata = 8'h20;
      unique case (state)
         CLEAR, ROWCLR: we = 1'b1;
         IDLE: begin
            if (accept && is_print) begin
               we    = 1'b1;
               waddr = cur_addr;
               wdata = wr.wr_data;
            end else if (accept && is_bs && cursor_col != 7'd0) begin
               we    = 1'b1;
               waddr = cur_addr - AW'(1);
            end
         end
         default: we = 1'b0;
      endcase
   end

   // Clear span is loaded as [base, end] so one counter serves both wipes.
   always_ff @(posedge CLK_PIX or posedge RST) begin
      if (RST) begin
         cursor_col <= 7'd0;
         cursor_row <= 5'd0;
         clr_addr   <= '0;
         clr_end    <= AW'(CELLS - 1);
      end else if (idle) begin
         if (accept) begin
            unique case (1'b1)
               is_print: begin
                  if (last_col) begin
                     cursor_col <= 7'd0;
                     cursor_row <= row_nxt;
                  end else begin
                     cursor_col <= cursor_col + 7'd1;
                  end
               end
               is_lf: begin
                  cursor_col <= 7'd0;
                  cursor_row <= row_nxt;
               end
               is_cr: cursor_col <= 7'd0;
               is_bs: if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
               default: ;
            endcase
         end
         if (row_adv) begin
            clr_addr <= row_base;
            clr_end  <= row_base + AW'(COLS - 1);
         end
      end else begin
         clr_addr <= clr_addr + AW'(1);
      end
   end

   always_ff @(posedge CLK_PIX) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge CLK_PIX or posedge RST) begin
      if (RST)        rd_char <= 8'h20;
      else if (rd_in) rd_char <= mem[rd_addr];
      else            rd_char <= 8'h20;
   end

`ifdef TEXTBUF_CURSOR_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);

   logic [FW-1:0] fcnt;
   logic          phase;
   logic [6:0]    rd_col_q;
   logic [4:0]    rd_row_q;

   // Typing restarts the blink so the cursor is visible while editing.
   always_ff @(posedge CLK_PIX or posedge RST) begin
      if (RST) begin
         fcnt     <= '0;
         phase    <= 1'b0;
         rd_col_q <= 7'd0;
         rd_row_q <= 5'd0;
      end else begin
         rd_col_q <= rd_col;
         rd_row_q <= rd_row;
         if (accept && (is_print || is_bs)) begin
            fcnt  <= '0;
            phase <= 1'b1;
         end else if (frame_start) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
         end
      end
   end

   assign rd_cursor = phase & (rd_col_q == cursor_col) & (rd_row_q == cursor_row);
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_frame_start;

   assign unused_frame_start = frame_start;
   assign rd_cursor          = 1'b0;
`endif

endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed self-checking bench for text_screen_buffer.
// Expected values are hand-derived from the default 60x17 geometry.
module tb_text_screen_buffer;

   logic       CLK_PIX = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] rd_col = 7'd0;
   logic [4:0] rd_row = 5'd0;
   logic [7:0] rd_char;
   logic       rd_cursor;
   logic       frame_start = 1'b0;
   logic [6:0] cursor_col;
   logic [4:0] cursor_row;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   text_screen_buffer_if wr ();

   text_screen_buffer #(.COLS(60), .ROWS(17), .BLINK_FRAMES(30)) dut (
      .CLK_PIX     (CLK_PIX),
      .RST         (RST),
      .wr          (wr.slave),
      .rd_col      (rd_col),
      .rd_row      (rd_row),
      .rd_char     (rd_char),
      .rd_cursor   (rd_cursor),
      .frame_start (frame_start),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .busy        (busy)
   );

   always #5 CLK_PIX = ~CLK_PIX;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_PIX);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!wr.wr_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!wr.wr_ready) chk("ready_timeout", 0, 1);
      wr.wr_valid = 1'b1;
      wr.wr_data  = b;
      tick();
      wr.wr_valid = 1'b0;
   endtask

   task automatic rd(input int c, input int r, output logic [7:0] ch);
      rd_col = 7'(c);
      rd_row = 5'(r);
      tick();
      ch = rd_char;
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic frames(input int k);
      for (int i = 0; i < k; i++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
   endtask

   task automatic chk_cur(input string tag, input int c, input int r);
      chk({tag, "_col"}, int'(cursor_col), c);
      chk({tag, "_row"}, int'(cursor_row), r);
   endtask

   initial begin
      logic [7:0] ch;
      int n;
      int bad;
      int exp_blink;

      wr.wr_valid = 1'b0;
      wr.wr_data  = 8'h00;
      tick();
      tick();
      chk("rst_ready", int'(wr.wr_ready), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_rd_char", int'(rd_char), 'h20);
      chk("rst_rd_cursor", int'(rd_cursor), 0);
      chk_cur("rst_cur", 0, 0);

      RST = 1'b0;
      busy_len(n);
      chk("clear_len", n, 1020);
      chk("ready_after_clear", int'(wr.wr_ready), 1);
      rd(0, 0, ch);
      chk("clr_0_0", int'(ch), 'h20);
      rd(59, 16, ch);
      chk("clr_59_16", int'(ch), 'h20);

      send(8'h41);
      send(8'h42);
      chk_cur("ab_cur", 2, 0);
      rd(0, 0, ch);
      chk("ab_0_0", int'(ch), 'h41);
      rd(1, 0, ch);
      chk("ab_1_0", int'(ch), 'h42);

      send(8'h0D);
      chk_cur("cr_cur", 0, 0);
      for (int i = 0; i < 60; i++) send(8'h58);
      chk_cur("wrap_cur", 0, 1);
      chk("rowclr_ready", int'(wr.wr_ready), 0);
      busy_len(n);
      chk("rowclr_len", n, 60);
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         rd(c, 1, ch);
         if (ch != 8'h20) bad++;
      end
      chk("row1_blank_bad", bad, 0);
      rd(59, 0, ch);
      chk("x_59_0", int'(ch), 'h58);
      rd(0, 0, ch);
      chk("x_0_0", int'(ch), 'h58);

      send(8'h5A);
      for (int i = 0; i < 15; i++) send(8'h0A);
      chk_cur("lf15_cur", 0, 16);
      rd(0, 1, ch);
      chk("z_0_1", int'(ch), 'h5A);
      send(8'h0A);
      chk_cur("lf_wrap_cur", 0, 0);
      busy_len(n);
      chk("lf_rowclr_len", n, 60);
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         rd(c, 0, ch);
         if (ch != 8'h20) bad++;
      end
      chk("row0_blank_bad", bad, 0);
      rd(60, 0, ch);
      chk("oob_col60", int'(ch), 'h20);
      rd(0, 17, ch);
      chk("oob_row17", int'(ch), 'h20);

      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(8'h08);
      chk_cur("bs_cur", 2, 0);
      rd(2, 0, ch);
      chk("bs_2_0", int'(ch), 'h20);
      send(8'h0D);
      send(8'h08);
      chk_cur("bs0_cur", 0, 0);
      send(8'h07);
      send(8'h7F);
      chk_cur("junk_cur", 0, 0);
      chk("junk_ready", int'(wr.wr_ready), 1);
      rd(0, 0, ch);
      chk("keep_0_0", int'(ch), 'h61);
      rd(1, 0, ch);
      chk("keep_1_0", int'(ch), 'h62);
      rd(2, 0, ch);
      chk("keep_2_0", int'(ch), 'h20);

      send(8'h61);
      send(8'h62);
      rd_col = 7'd2;
      rd_row = 5'd0;
      wr.wr_valid = 1'b1;
      wr.wr_data  = 8'h51;
      tick();
      wr.wr_valid = 1'b0;
      chk("read_first", int'(rd_char), 'h20);
      rd(2, 0, ch);
      chk("q_2_0", int'(ch), 'h51);
      send(8'h08);
      chk_cur("blink_cur", 2, 0);

`ifdef TEXTBUF_CURSOR_EN
      exp_blink = 1;
`else
      exp_blink = 0;
`endif
      chk("blink_on", int'(rd_cursor), exp_blink);
      frames(29);
      chk("blink_29", int'(rd_cursor), exp_blink);
      frames(1);
      chk("blink_30", int'(rd_cursor), 0);
      frames(30);
      chk("blink_60", int'(rd_cursor), exp_blink);
      rd(3, 0, ch);
      chk("blink_other_cell", int'(rd_cursor), 0);

      send(8'h0A);
      repeat (5) tick();
      chk("mid_rowclr_busy", int'(busy), 1);
      RST = 1'b1;
      tick();
      chk("rerst_ready", int'(wr.wr_ready), 0);
      chk_cur("rerst_cur", 0, 0);
      RST = 1'b0;
      busy_len(n);
      chk("reclear_len", n, 1020);
      rd(2, 0, ch);
      chk("reclear_2_0", int'(ch), 'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/text_screen_buffer.md
# text_screen_buffer

Character-cell text memory that sits directly upstream of the ASCII glyph renderer on the `CLK_PIX` domain. It accepts a byte stream from a writer such as a UART receiver over a valid/ready handshake and interprets basic control codes. It keeps a cursor and a `COLS`×`ROWS` array of character codes. The renderer reads it by cell coordinate and receives the code that it turns into a font-ROM address.

## Interface
- `COLS`, 60: text columns (480 px / 8); max 128.
- `ROWS`, 17: text rows (272 px / 16); max 32.
- `BLINK_FRAMES`, 30: frames per cursor blink half-period (used only with `TEXTBUF_CURSOR_EN`).
- `CLK_PIX` in 1: pixel clock; the block's only clock.
- `RST` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: writer has a byte.
- `wr_ready` out 1: block can accept a byte this cycle.
- `wr_data` in 8: byte to write or control code.
- `rd_col` in 7: renderer column (`number_of_column`).
- `rd_row` in 5: renderer text row.
- `rd_char` out 8: character code at (`rd_row`, `rd_col`); 1-cycle latency.
- `rd_cursor` out 1: cursor overlay flag, aligned with `rd_char`.
- `frame_start` in 1: one-cycle pulse per frame, from the timing generator.
- `cursor_col` out 7: current cursor column.
- `cursor_row` out 5: current cursor row.
- `busy` out 1: a clear operation is in progress.

## Operation
- Storage: `COLS*ROWS` × 8-bit dual-port RAM; address = `row*COLS + col`.
- FSM has three states:
  - CLEAR: entered on reset. Writes 0x20 to every cell, one per cycle, then goes to IDLE.
  - IDLE: accepts writer bytes.
  - ROWCLR: writes 0x20 to the `COLS` cells of `cursor_row`, then goes to IDLE.
- `wr_ready` = (state == IDLE). `busy` = (state != IDLE).
- A transfer occurs when `wr_valid & wr_ready`. One byte per cycle is sustainable in IDLE.
- Byte handling on transfer:
  - 0x20–0x7E: store the byte at the cursor, then `col+1`. If `col == COLS-1`, the cursor goes to column 0 of the next row.
  - 0x0D (CR): `col = 0`.
  - 0x0A (LF): `col = 0`, row advances.
  - 0x08 (BS): if `col > 0`, `col-1` and store 0x20 at the new position. At `col == 0`, no-op.
  - Any other byte: accepted and discarded.
- Row advance: the row increments, wrapping from `ROWS-1` to 0. Every row advance enters ROWCLR for the destination row, so old text is erased.
- Read port:
  - `rd_char` is registered; it returns RAM content one cycle after `rd_col`/`rd_row` are presented.
  - Coordinates out of range (`rd_col >= COLS` or `rd_row >= ROWS`) return 0x20.
  - Read and write to the same cell in the same cycle returns the old data (read-first).
- Reads are never stalled by writes or clears. During CLEAR, cells not yet cleared return their previous content.

## Timing
- Reset values:
  - `wr_ready` = 0, `busy` = 1, `rd_char` = 0x20, `rd_cursor` = 0.
  - `cursor_col` = 0, `cursor_row` = 0.
  - State = CLEAR; blink counter and phase = 0.
- After `RST` falls, CLEAR lasts exactly `COLS*ROWS` cycles (1020 at defaults). `wr_ready` rises on the following cycle.
- Cursor outputs and RAM contents update on the cycle after the accepting edge.
- ROWCLR:
  - Starts the cycle after the byte that caused the row advance.
  - Lasts exactly `COLS` cycles with `wr_ready` low.
  - IDLE resumes on the next cycle.
- Asserting `RST` mid-CLEAR or mid-ROWCLR aborts the operation and restarts CLEAR from cell 0.
- `frame_start` may coincide with any write. The two have no interaction except the blink restart described under Configuration.

## Configuration
- `TEXTBUF_CURSOR_EN` defined:
  - A frame counter counts `frame_start` pulses. At `BLINK_FRAMES-1` it clears and toggles the blink phase.
  - Any accepted printable byte or BS forces phase = 1 and clears the counter.
  - `rd_cursor` = phase & (registered read address == cursor position), aligned with `rd_char`.
- `TEXTBUF_CURSOR_EN` undefined: no counter logic is built and `rd_cursor` is tied to 0.

## Test plan
- Reset: `busy` stays 1 for 1020 cycles after `RST` falls, then `wr_ready` = 1. Reads at (0,0) and (59,16) both return 0x20.
- Write "AB" from reset: reads at (0,0) = 0x41 and (1,0) = 0x42 one cycle after the address is presented. Cursor = (2,0).
- Write 60 × 'X': the cursor reaches (0,1) and `wr_ready` is low for 60 cycles. Row 1 then reads all 0x20 and (59,0) reads 0x58.
- With cursor at row 16, send LF: cursor = (0,0). After 60 cycles every cell in row 0 reads 0x20. Reads at (60,0) and (0,17) return 0x20.
- Write "abc" then BS: cursor = (2,0), cell (2,0) = 0x20. A further CR then BS leaves the cursor at (0,0) and the cells unchanged. Bytes 0x07 and 0x7F are accepted with no effect.
- With `TEXTBUF_CURSOR_EN` defined, cursor at (2,0), reading (2,0): after a write, `rd_cursor` = 1 and toggles after every 30 `frame_start` pulses. Reading (3,0) gives `rd_cursor` = 0. With the macro undefined, `rd_cursor` stays 0 throughout.
